// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: holds the fetch PC, picks BTB target or PC+4, and handles boot/redirect bubbles.
// The BTB prediction path is present only when BTB_PREDICT_EN is defined; otherwise fetch is purely sequential.
module fetch_pc_gen #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] btb_raddr_o,
    input  logic [ADDR_WIDTH-1:0] btb_tag_i,
    input  logic [ADDR_WIDTH-1:0] btb_target_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  pc_valid_o,
    input  logic                  pc_ready_i,
    output logic                  pred_taken_o,
    output logic [ADDR_WIDTH-1:0] pred_target_o,
    output logic [CNT_WIDTH-1:0]  redirect_cnt_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   w_pc_nxt;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [ADDR_WIDTH-1:0]   w_pc_plus4;
    logic                    w_hit;
    logic [ADDR_WIDTH-1:0]   w_pred_target;

    assign w_pc_plus4 = r_pc + ADDR_WIDTH'(4);

`ifdef BTB_PREDICT_EN
    // An all-zero entry is the BTB's empty marker and must never hit, even at PC 0.
    assign w_hit         = (btb_tag_i == r_pc) && ({btb_target_i, btb_tag_i} != '0);
    assign w_pred_target = w_hit ? btb_target_i : w_pc_plus4;
    assign btb_raddr_o   = r_pc;
`else
    logic w_unused_btb;
    assign w_unused_btb  = ^{btb_tag_i, btb_target_i};
    assign w_hit         = 1'b0;
    assign w_pred_target = w_pc_plus4;
    assign btb_raddr_o   = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (redirect_i && !(&r_cnt)) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Redirect wins over everything in any state; a handshake in the same cycle is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (redirect_i) begin
            w_state_nxt = FLUSH;
            w_pc_nxt    = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
        end else begin
            case (r_state)
                BOOT:    w_state_nxt = RUN;
                RUN: begin
                    if (pc_ready_i) begin
                        w_pc_nxt = {w_pred_target[ADDR_WIDTH-1:2], 2'b00};
                    end
                end
                FLUSH:   w_state_nxt = RUN;
                default: w_state_nxt = BOOT;
            endcase
        end
    end

    assign pc_o           = r_pc;
    assign pc_valid_o     = (r_state == RUN);
    assign pred_taken_o   = w_hit;
    assign pred_target_o  = w_pred_target;
    assign redirect_cnt_o = r_cnt;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: boot, sequential fetch, BTB hit, stall, redirects, counter saturation, wrap.
module tb_fetch_pc_gen;

`ifdef BTB_PREDICT_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] btb_raddr_o;
    logic [31:0] btb_tag_i;
    logic [31:0] btb_target_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        pc_ready_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic [15:0] redirect_cnt_o;

    logic [31:0] s_btb_raddr_o;
    logic [31:0] s_pc_o;
    logic        s_pc_valid_o;
    logic        s_pred_taken_o;
    logic [31:0] s_pred_target_o;
    logic [1:0]  s_redirect_cnt_o;

    int total;
    int bad;

    fetch_pc_gen #(.ADDR_WIDTH(32), .RESET_PC(32'h100), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .btb_raddr_o(btb_raddr_o), .btb_tag_i(btb_tag_i),
        .btb_target_i(btb_target_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pc_ready_i(pc_ready_i),
        .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
        .redirect_cnt_o(redirect_cnt_o)
    );

    fetch_pc_gen #(.ADDR_WIDTH(32), .RESET_PC(32'h100), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .btb_raddr_o(s_btb_raddr_o), .btb_tag_i(btb_tag_i),
        .btb_target_i(btb_target_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .pc_o(s_pc_o), .pc_valid_o(s_pc_valid_o), .pc_ready_i(pc_ready_i),
        .pred_taken_o(s_pred_taken_o), .pred_target_o(s_pred_target_o),
        .redirect_cnt_o(s_redirect_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        pc_ready_i = 1'b1; btb_tag_i = '0; btb_target_i = '0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        pc_ready_i = 1'b1; btb_tag_i = '0; btb_target_i = '0;
        step(); step();
        total++; if (pc_o !== 32'h100) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h100); end
        total++; if (pc_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pc_valid_o); end
        total++; if (redirect_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", redirect_cnt_o); end
        total++; if (pred_target_o !== 32'h104) begin bad++; $display("FAIL reset_pred_target got=%h exp=%h", pred_target_o, 32'h104); end
        total++; if (btb_raddr_o !== (PRED_EN ? 32'h100 : 32'h0)) begin bad++; $display("FAIL reset_raddr got=%h", btb_raddr_o); end
        rst = 1'b0;
        step();
        total++; if (pc_valid_o !== 1'b1 || pc_o !== 32'h100) begin bad++; $display("FAIL first_fetch got=%b/%h exp=1/100", pc_valid_o, pc_o); end
        step();
        total++; if (pc_o !== 32'h104) begin bad++; $display("FAIL seq_104 got=%h exp=104", pc_o); end
        step();
        total++; if (pc_o !== 32'h108 || pc_valid_o !== 1'b1) begin bad++; $display("FAIL seq_108 got=%h/%b exp=108/1", pc_o, pc_valid_o); end
        total++; if (redirect_cnt_o !== 16'd0) begin bad++; $display("FAIL seq_cnt got=%0d exp=0", redirect_cnt_o); end
    endtask

    task automatic test_btb_hit();
        do_reset();
        btb_tag_i = 32'h108; btb_target_i = 32'h200;
        total++; if (pred_taken_o !== 1'b0) begin bad++; $display("FAIL hit_miss_100 got=%b exp=0", pred_taken_o); end
        step();
        total++; if (pc_o !== 32'h104 || pred_taken_o !== 1'b0) begin bad++; $display("FAIL hit_104 got=%h/%b exp=104/0", pc_o, pred_taken_o); end
        step();
        total++; if (pc_o !== 32'h108 || pred_taken_o !== PRED_EN) begin bad++; $display("FAIL hit_108 got=%h/%b exp=108/%b", pc_o, pred_taken_o, PRED_EN); end
        total++; if (pred_target_o !== (PRED_EN ? 32'h200 : 32'h10C)) begin bad++; $display("FAIL hit_target got=%h", pred_target_o); end
        step();
        total++; if (pc_o !== (PRED_EN ? 32'h200 : 32'h10C) || pred_taken_o !== 1'b0) begin bad++; $display("FAIL hit_next got=%h/%b", pc_o, pred_taken_o); end
        step();
        total++; if (pc_o !== (PRED_EN ? 32'h204 : 32'h110)) begin bad++; $display("FAIL hit_after got=%h", pc_o); end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        pc_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (pc_o !== 32'h104 || pc_valid_o !== 1'b1 || pred_target_o !== 32'h108) begin
                bad++; $display("FAIL stall_hold[%0d] got=%h/%b/%h exp=104/1/108", i, pc_o, pc_valid_o, pred_target_o);
            end
        end
        pc_ready_i = 1'b1;
        step();
        total++; if (pc_o !== 32'h108) begin bad++; $display("FAIL stall_resume got=%h exp=108", pc_o); end
    endtask

    task automatic test_redirect();
        do_reset();
        btb_tag_i = 32'h104; btb_target_i = 32'h300;
        step();
        pc_ready_i = 1'b0;
        step();
        total++; if (pc_o !== 32'h104 || pred_taken_o !== PRED_EN) begin bad++; $display("FAIL redir_stall got=%h/%b", pc_o, pred_taken_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h403;
        step();
        redirect_i = 1'b0; pc_ready_i = 1'b1;
        total++; if (pc_o !== 32'h400 || pc_valid_o !== 1'b0) begin bad++; $display("FAIL redir_bubble got=%h/%b exp=400/0", pc_o, pc_valid_o); end
        total++; if (redirect_cnt_o !== 16'd1) begin bad++; $display("FAIL redir_cnt got=%0d exp=1", redirect_cnt_o); end
        step();
        total++; if (pc_o !== 32'h400 || pc_valid_o !== 1'b1) begin bad++; $display("FAIL redir_first got=%h/%b exp=400/1", pc_o, pc_valid_o); end
        step();
        total++; if (pc_o !== 32'h404 || pc_valid_o !== 1'b1) begin bad++; $display("FAIL redir_second got=%h/%b exp=404/1", pc_o, pc_valid_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        redirect_i = 1'b1; redirect_pc_i = 32'h500;
        step();
        total++; if (pc_o !== 32'h500 || pc_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_first got=%h/%b exp=500/0", pc_o, pc_valid_o); end
        redirect_pc_i = 32'h600;
        step();
        redirect_i = 1'b0;
        total++; if (pc_o !== 32'h600 || pc_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_second got=%h/%b exp=600/0", pc_o, pc_valid_o); end
        step();
        total++; if (pc_o !== 32'h600 || pc_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%h/%b exp=600/1", pc_o, pc_valid_o); end
        total++; if (redirect_cnt_o !== 16'd2 || s_redirect_cnt_o !== 2'd2) begin bad++; $display("FAIL b2b_cnt got=%0d/%0d exp=2/2", redirect_cnt_o, s_redirect_cnt_o); end
    endtask

    task automatic test_saturate();
        // Continues from test_back_to_back with two redirects already counted.
        for (int i = 0; i < 3; i++) begin
            redirect_i = 1'b1; redirect_pc_i = 32'h700;
            step();
            total++; if (s_redirect_cnt_o !== 2'd3) begin bad++; $display("FAIL sat_cnt2[%0d] got=%0d exp=3", i, s_redirect_cnt_o); end
        end
        redirect_i = 1'b0;
        step();
        total++; if (redirect_cnt_o !== 16'd5) begin bad++; $display("FAIL sat_cnt16 got=%0d exp=5", redirect_cnt_o); end
    endtask

    task automatic test_wrap();
        btb_tag_i = '0; btb_target_i = '0;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        step();
        total++; if (pc_o !== 32'hFFFF_FFFC || pred_target_o !== 32'h0) begin bad++; $display("FAIL wrap_pre got=%h/%h exp=fffffffc/0", pc_o, pred_target_o); end
        step();
        total++; if (pc_o !== 32'h0 || pc_valid_o !== 1'b1) begin bad++; $display("FAIL wrap_zero got=%h/%b exp=0/1", pc_o, pc_valid_o); end
        total++; if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h4) begin bad++; $display("FAIL wrap_empty_entry got=%b/%h exp=0/4", pred_taken_o, pred_target_o); end
    endtask

    task automatic test_reset_redirect();
        rst = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h800;
        step();
        total++; if (pc_o !== 32'h100 || pc_valid_o !== 1'b0) begin bad++; $display("FAIL rstred_pc got=%h/%b exp=100/0", pc_o, pc_valid_o); end
        total++; if (redirect_cnt_o !== 16'd0 || s_redirect_cnt_o !== 2'd0) begin bad++; $display("FAIL rstred_cnt got=%0d/%0d exp=0/0", redirect_cnt_o, s_redirect_cnt_o); end
        rst = 1'b0; redirect_i = 1'b0;
        step();
        total++; if (pc_o !== 32'h100 || pc_valid_o !== 1'b1) begin bad++; $display("FAIL rstred_boot got=%h/%b exp=100/1", pc_o, pc_valid_o); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        pc_ready_i = 1'b1; btb_tag_i = '0; btb_target_i = '0;
        test_reset();
        test_btb_hit();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_saturate();
        test_wrap();
        test_reset_redirect();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage next-PC generator sitting directly upstream of the branch target buffer: it drives the BTB read address with the current fetch PC and consumes the returned entry to choose the next PC. It holds the architectural fetch PC register, sequences reset/boot and misprediction-redirect bubbles with a small state machine, and presents each fetched PC with its prediction to decode over a valid/ready handshake. Redirects from the execute-stage branch resolution always override predictions.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC and BTB tag/target width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- CNT_WIDTH, 16, width of the redirect counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- btb_raddr_o  out  ADDR_WIDTH  BTB read address, equals pc_o (combinational)
- btb_tag_i  in  ADDR_WIDTH  entry tag (stored branch address) from BTB
- btb_target_i  in  ADDR_WIDTH  entry branch target from BTB
- redirect_i  in  1  execute-stage mispredict/redirect strobe
- redirect_pc_i  in  ADDR_WIDTH  correct PC on redirect
- pc_o  out  ADDR_WIDTH  current fetch PC (registered)
- pc_valid_o  out  1  pc_o carries a fetch to decode
- pc_ready_i  in  1  decode accepts pc_o
- pred_taken_o  out  1  prediction for pc_o: taken
- pred_target_o  out  ADDR_WIDTH  predicted next PC for pc_o
- redirect_cnt_o  out  CNT_WIDTH  saturating count of accepted redirects

## Operation
- BTB hit: btb_tag_i == pc_o and {btb_target_i, btb_tag_i} != 0 (all-zero entry is invalid).
- pred_taken_o = hit; pred_target_o = hit ? btb_target_i : pc_o + 4. Combinational from pc_o and BTB data.
- pc + 4 is modulo 2^ADDR_WIDTH; 'hFFFF_FFFC + 4 wraps to 0.
- redirect_pc_i and btb_target_i low 2 bits forced to 0 before loading into PC.
- States: BOOT, RUN, FLUSH.
  - BOOT: entered on rst; pc_o = RESET_PC, pc_valid_o = 0; next cycle -> RUN.
  - RUN: pc_valid_o = 1. On pc_valid_o && pc_ready_i: pc <= pred_target_o. Otherwise hold pc (stall), outputs stable.
  - FLUSH: one bubble cycle, pc_valid_o = 0, pc holds redirect target; next cycle -> RUN.
- redirect_i in any state (not rst): pc <= redirect_pc_i, state <= FLUSH, redirect_cnt_o increments (saturates at all-ones). Redirect has priority over handshake and stall; any in-progress handshake that cycle is considered squashed by decode.
- Redirect while in FLUSH: reload pc with new target, stay in FLUSH one further cycle.
- rst has priority over everything, including redirect_i.

## Timing
- Reset values: pc_o = RESET_PC, pc_valid_o = 0, redirect_cnt_o = 0, state = BOOT; pred_taken_o/pred_target_o follow combinational rule on RESET_PC.
- First valid fetch: cycle after rst deasserts (rst high at edge N, low at N+1 -> pc_valid_o = 1 after edge N+1).
- Sequential fetch: one PC per cycle while pc_ready_i = 1; taken prediction costs zero bubbles.
- Redirect latency: redirect_i sampled at edge N -> pc_o = redirect_pc_i after N, pc_valid_o = 0 for that cycle, valid again after edge N+1 (one bubble).
- Stall: pc_valid_o held high, pc_o/pred outputs unchanged while pc_ready_i = 0 (BTB contents assumed stable; if BTB updates during stall, prediction outputs may change and that is legal).
- No combinational path from pc_ready_i or redirect_i to any output.

## Configuration
- BTB_PREDICT_EN defined: behaviour above.
- BTB_PREDICT_EN undefined: btb_raddr_o tied to 0, BTB inputs ignored, pred_taken_o = 0, pred_target_o = pc_o + 4 always; state machine, redirect and counter unchanged.

## Test plan
- Reset RESET_PC=32'h100, pc_ready_i=1, empty BTB -> after rst pc_o sequence 100,104,108 with pc_valid_o=1 from first post-reset cycle; redirect_cnt_o=0.
- BTB entry tag=32'h108, target=32'h200 -> pc_o 104,108,200,204; pred_taken_o=1 only while pc_o=108.
- pc_ready_i low 3 cycles at pc_o=32'h104 -> pc_o, pred_target_o, pc_valid_o held; resumes to 108.
- redirect_i with redirect_pc_i=32'h403 during a taken-hit stall -> next cycle pc_o=400, pc_valid_o=0, then valid 400,404; redirect_cnt_o=1.
- Back-to-back redirects to 500 then 600 -> two bubble cycles, first valid pc_o=600; counter=2; CNT_WIDTH=2 with 5 redirects -> counter stays 3.
- pc_o=32'hFFFF_FFFC, no hit -> next pc_o=0; rst asserted simultaneously with redirect_i -> pc_o=RESET_PC, state BOOT, counter 0.
